// File: rtl/memory_access_if.sv
// Data-bus bundle between the memory stage (master) and the data memory (slave).
// The request side stays stable from issue until the acknowledge is sampled.
interface memory_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/memory_access.sv
// RV32I memory stage: runs load/store bus transactions, forms the writeback value
// and publishes the forwarding pair (MEM_out, AM_out) back to execute.
module memory_access (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            IR,
  input  logic [31:0]            ALU,
  input  logic [31:0]            B,
  input  logic [31:0]            PC,
  input  logic                   v_in,
  output logic                   r_out,
  output logic                   v_out,
  input  logic                   r_in,
  output logic                   stall,
  output logic [31:0]            IR_out,
  output logic [31:0]            MEM_out,
  output logic [4:0]             AM_out,
  output logic                   fault,
  memory_access_if.master        bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP_IR   = 32'h0000_0013;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      r_state;
  logic        r_v_out;
  logic [31:0] r_ir_out;
  logic [31:0] r_mem_out;
  logic [4:0]  r_am_out;
  logic        r_fault;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic [31:0] r_pend_ir;
  logic [31:0] r_pend_alu;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd;
  logic [1:0]  w_a;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic        w_fault;
  logic [31:0] w_st_wdata;
  logic [3:0]  w_st_be;
  logic [31:0] w_alu_res;
  logic [4:0]  w_alu_rd;
  logic        w_accept;
  logic        w_pend_load;

  // Select and extend the addressed byte/halfword from a returned load word.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'd0, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'd0, h};
      default: res = d;
    endcase
    return res;
  endfunction

  assign w_opcode    = IR[6:0];
  assign w_f3        = IR[14:12];
  assign w_rd        = IR[11:7];
  assign w_a         = ALU[1:0];
  assign w_is_load   = (w_opcode == OP_LOAD);
  assign w_is_store  = (w_opcode == OP_STORE);
  assign w_is_mem    = w_is_load | w_is_store;
  assign w_accept    = v_in & r_out;
  assign w_pend_load = (r_pend_ir[6:0] == OP_LOAD);

  // Misalignment and illegal-funct3 detection for memory ops.
  always_comb begin
    w_fault = 1'b0;
    if (w_is_load) begin
      case (w_f3)
        3'b000, 3'b100: w_fault = 1'b0;
        3'b001, 3'b101: w_fault = w_a[0];
        3'b010:         w_fault = (w_a != 2'b00);
        default:        w_fault = 1'b1;
      endcase
    end else if (w_is_store) begin
      case (w_f3)
        3'b000:  w_fault = 1'b0;
        3'b001:  w_fault = w_a[0];
        3'b010:  w_fault = (w_a != 2'b00);
        default: w_fault = 1'b1;
      endcase
    end else begin
      w_fault = 1'b0;
    end
  end

  // Store lane replication and byte enables.
  always_comb begin
    w_st_wdata = B;
    w_st_be    = 4'b0000;
    case (w_f3)
      3'b000: begin
        w_st_wdata = {4{B[7:0]}};
        w_st_be    = 4'b0001 << w_a;
      end
      3'b001: begin
        w_st_wdata = {2{B[15:0]}};
        w_st_be    = 4'b0011 << {w_a[1], 1'b0};
      end
      3'b010: begin
        w_st_wdata = B;
        w_st_be    = 4'b1111;
      end
      default: begin
        w_st_wdata = B;
        w_st_be    = 4'b0000;
      end
    endcase
  end

  // Writeback value and destination for non-memory instructions.
  always_comb begin
    w_alu_res = ALU;
    w_alu_rd  = w_rd;
    if ((w_opcode == OP_JAL) || (w_opcode == OP_JALR)) begin
      w_alu_res = PC + 32'd4;
    end else begin
      w_alu_res = ALU;
    end
    if (w_opcode == OP_BRANCH) begin
      w_alu_rd = 5'd0;
    end else begin
      w_alu_rd = w_rd;
    end
  end

  // Stage FSM: IDLE accepts/completes single-cycle ops, WAIT holds the bus request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_v_out     <= 1'b0;
      r_ir_out    <= NOP_IR;
      r_mem_out   <= 32'd0;
      r_am_out    <= 5'd0;
      r_fault     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'b0000;
      r_pend_ir   <= NOP_IR;
      r_pend_alu  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mem && !w_fault) begin
              r_state     <= S_WAIT;
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_is_store;
              r_mem_addr  <= {ALU[31:2], 2'b00};
              r_mem_wdata <= w_is_store ? w_st_wdata : 32'd0;
              r_mem_be    <= w_is_store ? w_st_be : 4'b1111;
              r_pend_ir   <= IR;
              r_pend_alu  <= ALU;
              r_v_out     <= 1'b0;
              r_am_out    <= 5'd0;
              r_fault     <= 1'b0;
            end else begin
              r_v_out   <= 1'b1;
              r_ir_out  <= IR;
              r_mem_out <= w_is_mem ? ALU : w_alu_res;
              r_am_out  <= w_is_mem ? 5'd0 : w_alu_rd;
              r_fault   <= w_fault;
            end
          end else if (r_v_out && r_in) begin
            // Consumed with nothing new: AM_out drops so execute cannot forward stale data.
            r_v_out  <= 1'b0;
            r_am_out <= 5'd0;
            r_fault  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.mem_ack) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
            r_v_out   <= 1'b1;
            r_ir_out  <= r_pend_ir;
            r_mem_out <= w_pend_load ? load_extract(r_pend_ir[14:12], r_pend_alu[1:0], bus.mem_rdata)
                                     : r_pend_alu;
            r_am_out  <= w_pend_load ? r_pend_ir[11:7] : 5'd0;
            r_fault   <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign r_out         = (r_state == S_IDLE) && (!r_v_out || r_in);
  assign stall         = (r_state == S_WAIT) || (r_v_out && !r_in);
  assign v_out         = r_v_out;
  assign IR_out        = r_ir_out;
  assign MEM_out       = r_mem_out;
  assign AM_out        = r_am_out;
  assign fault         = r_fault;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;

endmodule

// File: tb/tb_memory_access.sv
// Directed and randomized bench for memory_access, checked against a behavioural
// model of the RV32I memory-stage rules.
module tb_memory_access;
  logic        clk;
  logic        rst;
  logic [31:0] IR, ALU, B, PC;
  logic        v_in, r_in;
  logic        r_out, v_out, stall, fault;
  logic [31:0] IR_out, MEM_out;
  logic [4:0]  AM_out;
  int          checks;
  int          failures;

  memory_access_if bus_if();

  memory_access dut (
    .clk(clk), .rst(rst), .IR(IR), .ALU(ALU), .B(B), .PC(PC),
    .v_in(v_in), .r_out(r_out), .v_out(v_out), .r_in(r_in), .stall(stall),
    .IR_out(IR_out), .MEM_out(MEM_out), .AM_out(AM_out), .fault(fault),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected result of a load from the returned word, by size/sign arithmetic.
  function automatic logic [31:0] load_model(input logic [2:0] f3, input int a, input logic [31:0] d);
    int unsigned size = f3 & 3;
    logic [31:0] v;
    if (size == 0) begin
      v = (d >> (8 * a)) & 32'h0000_00FF;
      if (f3[2] == 1'b0 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = (d >> (16 * (a / 2))) & 32'h0000_FFFF;
      if (f3[2] == 1'b0 && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  task automatic predict(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] b,
                         input logic [31:0] pc, output bit use_bus, output bit flt,
                         output logic [31:0] res, output logic [4:0] am, output bit we,
                         output logic [3:0] be, output logic [31:0] wdata);
    int op = ir[6:0];
    int f3 = ir[14:12];
    int a  = alu % 4;
    int size = f3 % 4;
    bit ld = (op == 3);
    bit st = (op == 35);
    bit legal;
    use_bus = 0; flt = 0; we = 0; be = 4'h0; wdata = 32'd0;
    res = alu;
    am  = ir[11:7];
    if (ld || st) begin
      legal = ld ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
      flt = !(legal && (a % (1 << size)) == 0);
      use_bus = !flt;
      we = st;
      if (ld) be = 4'hF;
      else    be = 4'(((1 << (1 << size)) - 1) << a);
      if (size == 0)      wdata = b[7:0] * 32'h0101_0101;
      else if (size == 1) wdata = b[15:0] * 32'h0001_0001;
      else                wdata = b;
      if (st || flt) am = 5'd0;
    end else begin
      if (op == 111 || op == 103) res = pc + 4;
      if (op == 99) am = 5'd0;
    end
  endtask

  task automatic issue(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] b,
                       input logic [31:0] pc);
    IR = ir; ALU = alu; B = b; PC = pc; v_in = 1'b1;
    chk("r_out_before_accept", 32'(r_out), 32'd1);
    tick();
    v_in = 1'b0;
  endtask

  // Hold the request for n cycles, acking on the last; checks mem_req each cycle.
  task automatic bus_wait(input int n, input logic [31:0] rdata, input string tag);
    for (int k = 1; k <= n; k++) begin
      chk({tag, "_req_hi"}, 32'(bus_if.mem_req), 32'd1);
      chk({tag, "_rout_lo"}, 32'(r_out), 32'd0);
      if (k == n) begin
        bus_if.mem_ack = 1'b1;
        bus_if.mem_rdata = rdata;
      end
      tick();
    end
    bus_if.mem_ack = 1'b0;
  endtask

  initial begin
    bit use_bus, flt, we;
    logic [31:0] res, wdata, ir, alu, b, pc, rdata;
    logic [4:0] am;
    logic [3:0] be;
    int n;
    int ops [10] = '{51, 19, 55, 111, 103, 99, 3, 3, 35, 35};

    checks = 0; failures = 0;
    rst = 1'b1; v_in = 1'b0; r_in = 1'b1;
    IR = 32'h13; ALU = 32'd0; B = 32'd0; PC = 32'd0;
    bus_if.mem_ack = 1'b0; bus_if.mem_rdata = 32'd0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_v_out", 32'(v_out), 32'd0);
    chk("rst_mem_req", 32'(bus_if.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus_if.mem_we), 32'd0);
    chk("rst_mem_addr", bus_if.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus_if.mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(bus_if.mem_be), 32'd0);
    chk("rst_IR_out", IR_out, 32'h0000_0013);
    chk("rst_MEM_out", MEM_out, 32'd0);
    chk("rst_AM_out", 32'(AM_out), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    // ADD x5 then back-to-back ADDI x9
    issue(32'h0000_02B3, 32'h0000_1234, 32'd0, 32'h10);
    chk("add_v_out", 32'(v_out), 32'd1);
    chk("add_MEM_out", MEM_out, 32'h1234);
    chk("add_AM_out", 32'(AM_out), 32'd5);
    chk("add_mem_req", 32'(bus_if.mem_req), 32'd0);
    issue(32'h0000_0493, 32'h0000_0055, 32'd0, 32'h14);
    chk("b2b_v_out", 32'(v_out), 32'd1);
    chk("b2b_MEM_out", MEM_out, 32'h55);
    chk("b2b_AM_out", 32'(AM_out), 32'd9);
    tick();
    chk("consume_v_out", 32'(v_out), 32'd0);
    chk("consume_AM_out", 32'(AM_out), 32'd0);

    // LB x7 at 0x103, three request cycles
    issue(32'h0000_0383, 32'h0000_0103, 32'd0, 32'h18);
    chk("lb_addr", bus_if.mem_addr, 32'h100);
    chk("lb_we", 32'(bus_if.mem_we), 32'd0);
    chk("lb_be", 32'(bus_if.mem_be), 32'hF);
    bus_wait(3, 32'h80FF_0000, "lb");
    chk("lb_v_out", 32'(v_out), 32'd1);
    chk("lb_MEM_out", MEM_out, 32'hFFFF_FF80);
    chk("lb_AM_out", 32'(AM_out), 32'd7);
    chk("lb_req_lo", 32'(bus_if.mem_req), 32'd0);
    tick();

    // SH at 0x202
    issue(32'h0000_1023, 32'h0000_0202, 32'hABCD_1234, 32'h1C);
    chk("sh_we", 32'(bus_if.mem_we), 32'd1);
    chk("sh_be", 32'(bus_if.mem_be), 32'hC);
    chk("sh_wdata", bus_if.mem_wdata, 32'h1234_1234);
    chk("sh_addr", bus_if.mem_addr, 32'h200);
    bus_wait(1, 32'hDEAD_BEEF, "sh");
    chk("sh_v_out", 32'(v_out), 32'd1);
    chk("sh_AM_out", 32'(AM_out), 32'd0);
    chk("sh_MEM_out", MEM_out, 32'h202);
    tick();

    // Misaligned LW x4
    issue(32'h0000_2203, 32'h0000_0101, 32'd0, 32'h20);
    chk("lwmis_req", 32'(bus_if.mem_req), 32'd0);
    chk("lwmis_v_out", 32'(v_out), 32'd1);
    chk("lwmis_fault", 32'(fault), 32'd1);
    chk("lwmis_AM_out", 32'(AM_out), 32'd0);
    tick();

    // JAL x1 at 0x40 under backpressure
    r_in = 1'b0;
    issue(32'h0000_00EF, 32'h0000_0900, 32'd0, 32'h40);
    for (int k = 0; k < 3; k++) begin
      chk("jal_v_out", 32'(v_out), 32'd1);
      chk("jal_MEM_out", MEM_out, 32'h44);
      chk("jal_AM_out", 32'(AM_out), 32'd1);
      chk("jal_r_out", 32'(r_out), 32'd0);
      chk("jal_stall", 32'(stall), 32'd1);
      if (k < 2) tick();
    end
    r_in = 1'b1;
    #1;
    chk("jal_release_r_out", 32'(r_out), 32'd1);
    chk("jal_release_stall", 32'(stall), 32'd0);
    tick();
    chk("jal_consumed", 32'(v_out), 32'd0);

    // Reset during WAIT, late ack ignored
    issue(32'h0000_2183, 32'h0000_0300, 32'd0, 32'h48);
    chk("rstw_req", 32'(bus_if.mem_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_req_lo", 32'(bus_if.mem_req), 32'd0);
    chk("rstw_v_out", 32'(v_out), 32'd0);
    chk("rstw_IR_out", IR_out, 32'h13);
    chk("rstw_addr", bus_if.mem_addr, 32'd0);
    chk("rstw_be", 32'(bus_if.mem_be), 32'd0);
    tick();
    bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'h1111_2222;
    tick();
    bus_if.mem_ack = 1'b0;
    tick();
    chk("rstw_late_v_out", 32'(v_out), 32'd0);
    chk("rstw_late_req", 32'(bus_if.mem_req), 32'd0);
    chk("rstw_late_MEM_out", MEM_out, 32'd0);
    chk("rstw_late_AM_out", 32'(AM_out), 32'd0);

    // Randomized instructions vs the behavioural model
    for (int it = 0; it < 60; it++) begin
      ir = $urandom;
      ir[6:0] = 7'(ops[$urandom_range(0, 9)]);
      if ($urandom_range(0, 5) == 0) ir[11:7] = 5'd0;
      alu = $urandom; b = $urandom; pc = $urandom & 32'hFFFF_FFFC;
      predict(ir, alu, b, pc, use_bus, flt, res, am, we, be, wdata);
      issue(ir, alu, b, pc);
      if (use_bus) begin
        chk("rnd_addr", bus_if.mem_addr, {alu[31:2], 2'b00});
        chk("rnd_we", 32'(bus_if.mem_we), 32'(we));
        chk("rnd_be", 32'(bus_if.mem_be), 32'(be));
        if (we) chk("rnd_wdata", bus_if.mem_wdata, wdata);
        chk("rnd_stall", 32'(stall), 32'd1);
        n = $urandom_range(1, 3);
        rdata = $urandom;
        bus_wait(n, rdata, "rnd");
        if (!we) res = load_model(ir[14:12], alu % 4, rdata);
      end else begin
        chk("rnd_noreq", 32'(bus_if.mem_req), 32'd0);
      end
      chk("rnd_v_out", 32'(v_out), 32'd1);
      chk("rnd_MEM_out", MEM_out, res);
      chk("rnd_AM_out", 32'(AM_out), 32'(am));
      chk("rnd_fault", 32'(fault), 32'(flt));
      chk("rnd_IR_out", IR_out, ir);
      if ($urandom_range(0, 2) == 0) begin
        r_in = 1'b0;
        tick();
        chk("rnd_hold_v_out", 32'(v_out), 32'd1);
        chk("rnd_hold_MEM_out", MEM_out, res);
        chk("rnd_hold_stall", 32'(stall), 32'd1);
        r_in = 1'b1;
      end
      tick();
      chk("rnd_consume_v_out", 32'(v_out), 32'd0);
      chk("rnd_consume_AM_out", 32'(AM_out), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
